traffic_lights_cfg_sequencer: RTL and testbench
===============================================

Name: traffic_lights_cfg_sequencer

Overview:
- Controller sitting in front of traffic_lights. It arbitrates timing-reconfiguration requests from two requesters (central controller, maintenance port) and serialises each one into the legal command sequence on the traffic_lights command bus.
- The sequence is: enter yellow-blink, load green/red/yellow times, restart at red.
- It also provides a priority OFF path that aborts any sequence in flight.

Parameters:
- CMD_GAP_CYC, 2, idle cycles inserted after every issued command (0 = back-to-back).
- AUTO_ON, 1, if 1 the sequence ends with the ON command (000); if 0 the light is left in yellow-blink.

Ports:
- clk_i  in  1  clock
- srst_i  in  1  synchronous active-high reset
- req0_valid_i  in  1  requester 0 has a config pending
- req0_ready_o  out  1  requester 0 granted; handshake completes when valid&&ready
- req0_red_ms_i / req0_yellow_ms_i / req0_green_ms_i  in  16 each  requester 0 times in ms (0 = keep current)
- req1_valid_i, req1_ready_o, req1_red_ms_i, req1_yellow_ms_i, req1_green_ms_i  same as requester 0, for requester 1
- off_i  in  1  OFF request, sampled every cycle
- cmd_type_o  out  3  to traffic_lights cmd_type_i
- cmd_valid_o  out  1  to traffic_lights cmd_valid_i
- cmd_data_o  out  16  to traffic_lights cmd_data_i
- busy_o  out  1  sequence in progress
- done_o  out  1  one-cycle pulse, sequence completed
- aborted_o  out  1  one-cycle pulse, sequence killed by off_i

Behaviour:
- **Reset values:** all outputs 0; FSM IDLE; round-robin pointer favours req0.
- **Command outputs:** registered. cmd_valid_o is a single-cycle pulse. When cmd_valid_o=0, cmd_type_o and cmd_data_o are 0. cmd_data_o is 0 for non-set commands.
- **FSM states:** IDLE, BLINK, SET_G, SET_R, SET_Y, ON, GAP, DONE.
- **IDLE, grant logic:** ready is combinational: readyN_o = (state==IDLE) && granted(N) && !off_i.
  - Only one valid: that requester is granted.
  - Both valid: the requester not served last is granted.
  - The pointer updates on handshake.
- **On handshake:** latch the three times; go to BLINK.
- **Command emission:** each command state emits its command in its cycle.
  - BLINK emits 010.
  - SET_G emits 011 with green.
  - SET_R emits 100 with red.
  - SET_Y emits 101 with yellow.
  - ON emits 000 (only when AUTO_ON=1).
- **Spacing:** after each emission, GAP holds CMD_GAP_CYC cycles (skipped when 0), then the next command state is entered.
- **Zero fields:** a SET state whose latched value is 0 is skipped entirely. No emission, no gap, zero cycles spent.
- **Completion:** after the last command and its gap, DONE lasts one cycle with done_o=1, then IDLE.
- **busy_o:** 1 from the cycle after handshake through DONE inclusive.
- **Latency (CMD_GAP_CYC=2, all fields non-zero, AUTO_ON=1, handshake at cycle 0):**
  - commands at cycles 1, 4, 7, 10, 13
  - done_o at 16 (last gap included)
  - new handshake possible at 17
- **off_i (highest priority):** when off_i=1 in any cycle N:
  - cycle N+1 emits 001 instead of whatever was due (due command dropped);
  - if busy, aborted_o=1 in N+1 and the sequence is discarded, with no done_o;
  - FSM returns to IDLE in N+2;
  - no grant is given while off_i=1.
- **off_i held:** 001 repeats every cycle; this is harmless.
- **srst_i mid-sequence:** in the next cycle all outputs are 0, no further commands are emitted, the pointer resets, latched values are discarded.
- **Input sampling:** request inputs are only sampled at handshake; later changes are ignored.

Test Plan:
1. **Single request.** req0 = (r=40, y=20, g=60), GAP=2. Required: 010@1, 011/60@4, 100/40@7, 101/20@10, 000@13; done_o@16; busy_o 1..16. Connected traffic_lights shows red_o=1 after 000.
2. **Contention.** req0 and req1 valid together out of reset. Required: req0 granted first; req1 granted at the first IDLE cycle after; with both re-asserted, req0 is granted next (alternation).
3. **Zero field.** Request g=0, r=30, y=10. Required: 010, 100/30, 101/10, 000 only, with no 011 emitted; done_o at cycle 13.
4. **OFF during a gap.** off_i pulse in the gap after 011. Required: next cycle emits 001 with aborted_o=1; no 100/101/000 follow; done_o stays 0; ready reasserts two cycles later.
5. **AUTO_ON=0, GAP=0.** Request (5, 6, 7). Required: commands on consecutive cycles 1..4 (010, 011/7, 100/5, 101/6), done_o@5; traffic_lights remains in yellow blink.
6. **Reset mid-sequence.** srst_i at cycle 5 of case 1. Required: all outputs 0 from cycle 6; no commands until a new handshake.

Source files
------------

// File: rtl/traffic_lights_cfg_sequencer.sv
// ---------------------------------------------------------------------------
// traffic_lights_cfg_sequencer
//
// Sits in front of a traffic_lights block and turns timing-reconfiguration
// requests into the legal command sequence on its command bus:
//   BLINK (010) -> SET_G (011) -> SET_R (100) -> SET_Y (101) -> ON (000)
// A SET command whose latched time is 0 is skipped. ON is only issued when
// AUTO_ON=1. Each issued command is followed by CMD_GAP_CYC idle cycles.
// Two requesters (0 = central controller, 1 = maintenance port) are
// arbitrated round-robin. off_i overrides everything: it emits OFF (001)
// the next cycle and discards any sequence in flight.
//
// Parameters
//   CMD_GAP_CYC  idle cycles after every issued command (0 = back-to-back)
//   AUTO_ON      1: finish with ON; 0: leave the light in yellow-blink
//
// Ports
//   clk_i               clock
//   srst_i              synchronous active-high reset
//   reqN_valid_i        requester N has a configuration pending
//   reqN_ready_o        requester N granted (combinational, IDLE only)
//   reqN_red_ms_i       requester N red time in ms (0 = keep current)
//   reqN_yellow_ms_i    requester N yellow time in ms (0 = keep current)
//   reqN_green_ms_i     requester N green time in ms (0 = keep current)
//   off_i               OFF request, sampled every cycle
//   cmd_type_o          command type to traffic_lights (registered)
//   cmd_valid_o         one-cycle command strobe (registered)
//   cmd_data_o          command payload, 0 for non-SET commands (registered)
//   busy_o              sequence in progress
//   done_o              one-cycle pulse, sequence completed
//   aborted_o           one-cycle pulse, sequence killed by off_i
// ---------------------------------------------------------------------------
module traffic_lights_cfg_sequencer #(
    parameter int CMD_GAP_CYC = 2,
    parameter bit AUTO_ON     = 1'b1
) (
    input  logic        clk_i,
    input  logic        srst_i,

    input  logic        req0_valid_i,
    output logic        req0_ready_o,
    input  logic [15:0] req0_red_ms_i,
    input  logic [15:0] req0_yellow_ms_i,
    input  logic [15:0] req0_green_ms_i,

    input  logic        req1_valid_i,
    output logic        req1_ready_o,
    input  logic [15:0] req1_red_ms_i,
    input  logic [15:0] req1_yellow_ms_i,
    input  logic [15:0] req1_green_ms_i,

    input  logic        off_i,

    output logic [2:0]  cmd_type_o,
    output logic        cmd_valid_o,
    output logic [15:0] cmd_data_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        aborted_o
);

    // Command encodings of the traffic_lights command bus
    localparam logic [2:0] CMD_ON    = 3'b000;
    localparam logic [2:0] CMD_OFF   = 3'b001;
    localparam logic [2:0] CMD_BLINK = 3'b010;
    localparam logic [2:0] CMD_SET_G = 3'b011;
    localparam logic [2:0] CMD_SET_R = 3'b100;
    localparam logic [2:0] CMD_SET_Y = 3'b101;

    localparam int GAP_W = (CMD_GAP_CYC > 1) ? $clog2(CMD_GAP_CYC) : 1;
    // The counter is loaded with GAP-1 so GAP holds exactly CMD_GAP_CYC cycles
    localparam logic [GAP_W-1:0] GAP_LOAD =
        GAP_W'((CMD_GAP_CYC > 0) ? (CMD_GAP_CYC - 1) : 0);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_BLINK = 3'd1,
        S_SET_G = 3'd2,
        S_SET_R = 3'd3,
        S_SET_Y = 3'd4,
        S_ON    = 3'd5,
        S_GAP   = 3'd6,
        S_DONE  = 3'd7
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t           state_reg, state_next;
    state_t           ret_reg, ret_next;        // command state to enter after GAP
    logic [GAP_W-1:0] gap_cnt_reg, gap_cnt_next;
    logic             rr_reg, rr_next;          // 1: req1 wins a tie
    logic [15:0]      red_reg, red_next;
    logic [15:0]      yellow_reg, yellow_next;
    logic [15:0]      green_reg, green_next;

    logic             cmd_valid_reg, cmd_valid_next;
    logic [2:0]       cmd_type_reg, cmd_type_next;
    logic [15:0]      cmd_data_reg, cmd_data_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic             aborted_reg, aborted_next;

    // ------------------------------------------------------------------
    // Requester arbitration
    // ------------------------------------------------------------------
    logic [1:0]  req_valid;
    logic [1:0]  grant;
    logic [1:0]  req_ready;
    logic [15:0] req_red    [2];
    logic [15:0] req_yellow [2];
    logic [15:0] req_green  [2];
    logic        handshake;
    logic [15:0] sel_red, sel_yellow, sel_green;

    assign req_valid     = {req1_valid_i, req0_valid_i};
    assign req_red[0]    = req0_red_ms_i;
    assign req_red[1]    = req1_red_ms_i;
    assign req_yellow[0] = req0_yellow_ms_i;
    assign req_yellow[1] = req1_yellow_ms_i;
    assign req_green[0]  = req0_green_ms_i;
    assign req_green[1]  = req1_green_ms_i;

    // A lone requester always wins; on a tie the one not served last wins.
    // Ready is also held low during reset so no handshake is lost to it.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req
            assign grant[gi]     = req_valid[gi] &&
                                   (!req_valid[1 - gi] || (rr_reg == 1'(gi)));
            assign req_ready[gi] = (state_reg == S_IDLE) && grant[gi] &&
                                   !off_i && !srst_i;
        end
    endgenerate

    assign req0_ready_o = req_ready[0];
    assign req1_ready_o = req_ready[1];
    assign handshake    = |req_ready;

    assign sel_red    = req_ready[1] ? req_red[1]    : req_red[0];
    assign sel_yellow = req_ready[1] ? req_yellow[1] : req_yellow[0];
    assign sel_green  = req_ready[1] ? req_green[1]  : req_green[0];

    // ------------------------------------------------------------------
    // Successor of each command state, skipping SET states whose time is 0.
    // Resolving the skip here means a skipped state costs no cycles at all.
    // ------------------------------------------------------------------
    state_t after_y, after_r, after_g, after_blink, follow;

    always_comb begin
        after_y     = AUTO_ON ? S_ON : S_DONE;
        after_r     = (yellow_reg != '0) ? S_SET_Y : after_y;
        after_g     = (red_reg    != '0) ? S_SET_R : after_r;
        after_blink = (green_reg  != '0) ? S_SET_G : after_g;
        case (state_reg)
            S_BLINK: follow = after_blink;
            S_SET_G: follow = after_g;
            S_SET_R: follow = after_r;
            S_SET_Y: follow = after_y;
            default: follow = S_DONE;
        endcase
    end

    // ------------------------------------------------------------------
    // Process 1: state register (also holds the registered outputs)
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_reg     <= S_IDLE;
            ret_reg       <= S_IDLE;
            gap_cnt_reg   <= '0;
            rr_reg        <= 1'b0;
            red_reg       <= '0;
            yellow_reg    <= '0;
            green_reg     <= '0;
            cmd_valid_reg <= 1'b0;
            cmd_type_reg  <= '0;
            cmd_data_reg  <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            aborted_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            ret_reg       <= ret_next;
            gap_cnt_reg   <= gap_cnt_next;
            rr_reg        <= rr_next;
            red_reg       <= red_next;
            yellow_reg    <= yellow_next;
            green_reg     <= green_next;
            cmd_valid_reg <= cmd_valid_next;
            cmd_type_reg  <= cmd_type_next;
            cmd_data_reg  <= cmd_data_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            aborted_reg   <= aborted_next;
        end
    end

    // ------------------------------------------------------------------
    // Process 2: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        ret_next     = ret_reg;
        gap_cnt_next = gap_cnt_reg;
        rr_next      = rr_reg;
        red_next     = red_reg;
        yellow_next  = yellow_reg;
        green_next   = green_reg;

        if (off_i) begin
            // DONE doubles as the one-cycle settle slot after an OFF, so the
            // FSM is back in IDLE two cycles after off_i and grants stay
            // blocked in between. done_o is suppressed for this case below.
            state_next = S_DONE;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (handshake) begin
                        red_next    = sel_red;
                        yellow_next = sel_yellow;
                        green_next  = sel_green;
                        rr_next     = req_ready[0];
                        state_next  = S_BLINK;
                    end
                end
                S_BLINK, S_SET_G, S_SET_R, S_SET_Y, S_ON: begin
                    if (CMD_GAP_CYC == 0) begin
                        state_next = follow;
                    end else begin
                        state_next   = S_GAP;
                        ret_next     = follow;
                        gap_cnt_next = GAP_LOAD;
                    end
                end
                S_GAP: begin
                    if (gap_cnt_reg == '0) begin
                        state_next = ret_reg;
                    end else begin
                        gap_cnt_next = gap_cnt_reg - 1'b1;
                    end
                end
                S_DONE:  state_next = S_IDLE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Process 3: output logic. Outputs are decoded from the state being
    // entered and registered, so each command appears during the cycle its
    // state is occupied.
    // ------------------------------------------------------------------
    always_comb begin
        cmd_valid_next = 1'b0;
        cmd_type_next  = CMD_ON;
        cmd_data_next  = '0;

        if (off_i) begin
            cmd_valid_next = 1'b1;
            cmd_type_next  = CMD_OFF;
        end else begin
            case (state_next)
                S_BLINK: begin
                    cmd_valid_next = 1'b1;
                    cmd_type_next  = CMD_BLINK;
                end
                S_SET_G: begin
                    cmd_valid_next = 1'b1;
                    cmd_type_next  = CMD_SET_G;
                    cmd_data_next  = green_reg;
                end
                S_SET_R: begin
                    cmd_valid_next = 1'b1;
                    cmd_type_next  = CMD_SET_R;
                    cmd_data_next  = red_reg;
                end
                S_SET_Y: begin
                    cmd_valid_next = 1'b1;
                    cmd_type_next  = CMD_SET_Y;
                    cmd_data_next  = yellow_reg;
                end
                S_ON: begin
                    cmd_valid_next = 1'b1;
                    cmd_type_next  = CMD_ON;
                end
                default: begin
                    cmd_valid_next = 1'b0;
                end
            endcase
        end

        busy_next    = (state_next != S_IDLE) && !off_i;
        done_next    = (state_next == S_DONE) && !off_i;
        // Only a sequence that was actually running reports an abort
        aborted_next = off_i && busy_reg;
    end

    assign cmd_valid_o = cmd_valid_reg;
    assign cmd_type_o  = cmd_type_reg;
    assign cmd_data_o  = cmd_data_reg;
    assign busy_o      = busy_reg;
    assign done_o      = done_reg;
    assign aborted_o   = aborted_reg;

endmodule

// File: tb/tb_traffic_lights_cfg_sequencer.sv
// ---------------------------------------------------------------------------
// Bench for traffic_lights_cfg_sequencer. Two instances:
//   dut index 0: CMD_GAP_CYC=2, AUTO_ON=1
//   dut index 1: CMD_GAP_CYC=0, AUTO_ON=0
// A per-cycle expectation table is filled from the command-sequence rules
// whenever a handshake, OFF or reset is seen; one process compares every
// output every cycle against it. Directed tests add literal checks.
// ---------------------------------------------------------------------------
module tb_traffic_lights_cfg_sequencer;

    localparam int NC = 2048;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    // Stimulus, [dut][requester]
    logic        srst [2];
    logic        off  [2];
    logic        v    [2][2];
    logic [15:0] in_r [2][2];
    logic [15:0] in_y [2][2];
    logic [15:0] in_g [2][2];

    // DUT outputs
    logic        rdy    [2][2];
    logic [2:0]  ctype  [2];
    logic        cvalid [2];
    logic [15:0] cdata  [2];
    logic        busy   [2];
    logic        done   [2];
    logic        abrt   [2];

    // Expectation table
    bit          e_valid [2][NC];
    logic [2:0]  e_type  [2][NC];
    logic [15:0] e_data  [2][NC];
    bit          e_done  [2][NC];
    bit          e_busy  [2][NC];
    bit          e_abort [2][NC];
    int          free_at [2];
    bit          pref1   [2];
    int          gap_p   [2];
    bit          auto_p  [2];

    traffic_lights_cfg_sequencer #(.CMD_GAP_CYC(2), .AUTO_ON(1'b1)) dut_a (
        .clk_i(clk), .srst_i(srst[0]),
        .req0_valid_i(v[0][0]), .req0_ready_o(rdy[0][0]),
        .req0_red_ms_i(in_r[0][0]), .req0_yellow_ms_i(in_y[0][0]), .req0_green_ms_i(in_g[0][0]),
        .req1_valid_i(v[0][1]), .req1_ready_o(rdy[0][1]),
        .req1_red_ms_i(in_r[0][1]), .req1_yellow_ms_i(in_y[0][1]), .req1_green_ms_i(in_g[0][1]),
        .off_i(off[0]),
        .cmd_type_o(ctype[0]), .cmd_valid_o(cvalid[0]), .cmd_data_o(cdata[0]),
        .busy_o(busy[0]), .done_o(done[0]), .aborted_o(abrt[0])
    );

    traffic_lights_cfg_sequencer #(.CMD_GAP_CYC(0), .AUTO_ON(1'b0)) dut_b (
        .clk_i(clk), .srst_i(srst[1]),
        .req0_valid_i(v[1][0]), .req0_ready_o(rdy[1][0]),
        .req0_red_ms_i(in_r[1][0]), .req0_yellow_ms_i(in_y[1][0]), .req0_green_ms_i(in_g[1][0]),
        .req1_valid_i(v[1][1]), .req1_ready_o(rdy[1][1]),
        .req1_red_ms_i(in_r[1][1]), .req1_yellow_ms_i(in_y[1][1]), .req1_green_ms_i(in_g[1][1]),
        .off_i(off[1]),
        .cmd_type_o(ctype[1]), .cmd_valid_o(cvalid[1]), .cmd_data_o(cdata[1]),
        .busy_o(busy[1]), .done_o(done[1]), .aborted_o(abrt[1])
    );

    task automatic chk(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d cyc=%0d got=%0h want=%0h", name, k, cyc, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Model
    // ------------------------------------------------------------------
    task automatic put_cmd(input int k, input int t, input logic [2:0] ty,
                           input logic [15:0] d);
        if (t < NC) begin
            e_valid[k][t] = 1'b1;
            e_type[k][t]  = ty;
            e_data[k][t]  = d;
        end
    endtask

    task automatic clear_after(input int k, input int c);
        for (int u = c + 1; u < NC; u++) begin
            e_valid[k][u] = 1'b0;
            e_type[k][u]  = 3'b000;
            e_data[k][u]  = 16'h0;
            e_done[k][u]  = 1'b0;
            e_busy[k][u]  = 1'b0;
            e_abort[k][u] = 1'b0;
        end
    endtask

    // Sequence for a handshake at cycle c: first command at c+1, each
    // command followed by gap idle cycles, zero fields dropped entirely.
    task automatic model_handshake(input int k, input int c, input int q,
                                   input logic [15:0] r, input logic [15:0] y,
                                   input logic [15:0] g);
        int t;
        t = c + 1;
        put_cmd(k, t, 3'b010, 16'h0); t += 1 + gap_p[k];
        if (g != 0) begin put_cmd(k, t, 3'b011, g); t += 1 + gap_p[k]; end
        if (r != 0) begin put_cmd(k, t, 3'b100, r); t += 1 + gap_p[k]; end
        if (y != 0) begin put_cmd(k, t, 3'b101, y); t += 1 + gap_p[k]; end
        if (auto_p[k]) begin put_cmd(k, t, 3'b000, 16'h0); t += 1 + gap_p[k]; end
        if (t < NC) e_done[k][t] = 1'b1;
        for (int u = c + 1; u <= t && u < NC; u++) e_busy[k][u] = 1'b1;
        free_at[k] = t + 1;
        pref1[k]   = (q == 0);
        $display("TXN dut%0d req%0d handshake_cyc=%0d red=%0d yellow=%0d green=%0d done_cyc=%0d",
                 k, q, c, r, y, g, t);
    endtask

    task automatic model_off(input int k, input int c);
        bit was_busy;
        was_busy = e_busy[k][c];
        clear_after(k, c);
        put_cmd(k, c + 1, 3'b001, 16'h0);
        if (c + 1 < NC) e_abort[k][c + 1] = was_busy;
        free_at[k] = c + 2;
    endtask

    task automatic model_reset(input int k, input int c);
        clear_after(k, c);
        free_at[k] = c + 1;
        pref1[k]   = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Per-cycle compare, sampled on the falling edge
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        int  c;
        bit  g0, g1, er0, er1;
        c = cyc;
        if (c < NC) begin
            for (int k = 0; k < 2; k++) begin
                g0  = v[k][0] && (!v[k][1] || !pref1[k]);
                g1  = v[k][1] && (!v[k][0] ||  pref1[k]);
                er0 = (c >= free_at[k]) && g0 && !off[k] && !srst[k];
                er1 = (c >= free_at[k]) && g1 && !off[k] && !srst[k];
                chk("ready0",    k, rdy[k][0], er0);
                chk("ready1",    k, rdy[k][1], er1);
                chk("cmd_valid", k, cvalid[k], e_valid[k][c]);
                chk("cmd_type",  k, ctype[k],  e_valid[k][c] ? e_type[k][c] : 3'b000);
                chk("cmd_data",  k, cdata[k],  e_valid[k][c] ? e_data[k][c] : 16'h0);
                chk("busy",      k, busy[k],   e_busy[k][c]);
                chk("done",      k, done[k],   e_done[k][c]);
                chk("aborted",   k, abrt[k],   e_abort[k][c]);
                if (srst[k])     model_reset(k, c);
                else if (off[k]) model_off(k, c);
                else if (er0)    model_handshake(k, c, 0, in_r[k][0], in_y[k][0], in_g[k][0]);
                else if (er1)    model_handshake(k, c, 1, in_r[k][1], in_y[k][1], in_g[k][1]);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_neg(input int c);
        forever begin
            @(negedge clk);
            if (cyc >= c) break;
        end
    endtask

    // Raise valid, wait (bounded) for the handshake, then drop valid and
    // scribble the fields to show later changes are ignored.
    task automatic request(input int k, input int q, input logic [15:0] r,
                           input logic [15:0] y, input logic [15:0] g,
                           output int h);
        tick;
        in_r[k][q] = r; in_y[k][q] = y; in_g[k][q] = g;
        v[k][q] = 1'b1;
        h = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rdy[k][q] === 1'b1) begin h = cyc; break; end
        end
        chk("handshake_seen", k, (h >= 0), 1);
        tick;
        v[k][q] = 1'b0;
        in_r[k][q] = 16'hFFFF; in_y[k][q] = 16'hFFFF; in_g[k][q] = 16'hFFFF;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int h, h0, h1, h2, c0;
        gap_p[0] = 2; auto_p[0] = 1'b1;
        gap_p[1] = 0; auto_p[1] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            srst[k] = 1'b1; off[k] = 1'b0; free_at[k] = 0; pref1[k] = 1'b0;
            for (int q = 0; q < 2; q++) begin
                v[k][q] = 1'b0; in_r[k][q] = 16'h0; in_y[k][q] = 16'h0; in_g[k][q] = 16'h0;
            end
        end
        repeat (3) tick;
        chk("reset_cmd_valid", 0, cvalid[0], 1'b0);
        chk("reset_busy",      0, busy[0],   1'b0);
        srst[0] = 1'b0; srst[1] = 1'b0;

        // 1: single request, GAP=2, AUTO_ON=1
        request(0, 0, 16'd40, 16'd20, 16'd60, h);
        wait_neg(h + 1);  chk("t1_blink", 0, {cvalid[0], ctype[0]}, 4'b1010);
        wait_neg(h + 4);  chk("t1_set_g", 0, {cvalid[0], ctype[0], cdata[0]}, {1'b1, 3'b011, 16'd60});
        wait_neg(h + 7);  chk("t1_set_r", 0, {cvalid[0], ctype[0], cdata[0]}, {1'b1, 3'b100, 16'd40});
        wait_neg(h + 10); chk("t1_set_y", 0, {cvalid[0], ctype[0], cdata[0]}, {1'b1, 3'b101, 16'd20});
        wait_neg(h + 13); chk("t1_on",    0, {cvalid[0], ctype[0]}, 4'b1000);
        wait_neg(h + 16); chk("t1_done",  0, {done[0], busy[0]}, 2'b11);
        wait_neg(h + 17); chk("t1_idle",  0, busy[0], 1'b0);

        // 2: contention out of reset
        tick; srst[0] = 1'b1;
        tick; srst[0] = 1'b0;
        tick;
        v[0][0] = 1'b1; in_r[0][0] = 16'd10; in_y[0][0] = 16'd11; in_g[0][0] = 16'd12;
        v[0][1] = 1'b1; in_r[0][1] = 16'd20; in_y[0][1] = 16'd21; in_g[0][1] = 16'd22;
        @(negedge clk);
        h0 = cyc;
        chk("t2_first_req0", 0, rdy[0][0], 1'b1);
        chk("t2_req1_waits", 0, rdy[0][1], 1'b0);
        tick; v[0][0] = 1'b0;
        h1 = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rdy[0][1] === 1'b1) begin h1 = cyc; break; end
        end
        chk("t2_req1_at_idle", 0, h1, h0 + 17);
        tick; v[0][0] = 1'b1; v[0][1] = 1'b1;
        h2 = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rdy[0][0] === 1'b1 || rdy[0][1] === 1'b1) begin h2 = cyc; break; end
        end
        chk("t2_alternate_req0", 0, {rdy[0][0], rdy[0][1]}, 2'b10);
        chk("t2_alternate_cyc",  0, h2, h1 + 17);
        tick; v[0][0] = 1'b0; v[0][1] = 1'b0;
        wait_neg(h2 + 17);

        // 3: zero green field
        request(0, 0, 16'd30, 16'd10, 16'd0, h);
        wait_neg(h + 4);  chk("t3_set_r", 0, {cvalid[0], ctype[0], cdata[0]}, {1'b1, 3'b100, 16'd30});
        wait_neg(h + 7);  chk("t3_set_y", 0, {cvalid[0], ctype[0], cdata[0]}, {1'b1, 3'b101, 16'd10});
        wait_neg(h + 13); chk("t3_done",  0, done[0], 1'b1);

        // 4: OFF in the gap after SET_G
        request(0, 0, 16'd1, 16'd2, 16'd3, h);
        wait_neg(h + 4);
        tick; off[0] = 1'b1;
        tick; off[0] = 1'b0;
        v[0][1] = 1'b1; in_r[0][1] = 16'd7; in_y[0][1] = 16'd8; in_g[0][1] = 16'd9;
        @(negedge clk);
        chk("t4_off_cmd", 0, {cvalid[0], ctype[0], cdata[0]}, {1'b1, 3'b001, 16'd0});
        chk("t4_aborted", 0, {abrt[0], done[0]}, 2'b10);
        chk("t4_no_grant_yet", 0, rdy[0][1], 1'b0);
        @(negedge clk);
        chk("t4_ready_back", 0, rdy[0][1], 1'b1);
        h1 = cyc;
        tick; v[0][1] = 1'b0;
        wait_neg(h1 + 17);

        // OFF held while idle: 001 every cycle, no abort
        tick; off[0] = 1'b1; c0 = cyc;
        repeat (3) tick;
        off[0] = 1'b0;
        @(negedge clk);
        chk("off_held_repeat", 0, {cvalid[0], ctype[0], abrt[0]}, {1'b1, 3'b001, 1'b0});
        repeat (3) tick;

        // 5: GAP=0, AUTO_ON=0
        request(1, 0, 16'd5, 16'd6, 16'd7, h);
        wait_neg(h + 1); chk("t5_blink", 1, {cvalid[1], ctype[1]}, 4'b1010);
        wait_neg(h + 2); chk("t5_set_g", 1, {cvalid[1], ctype[1], cdata[1]}, {1'b1, 3'b011, 16'd7});
        wait_neg(h + 3); chk("t5_set_r", 1, {cvalid[1], ctype[1], cdata[1]}, {1'b1, 3'b100, 16'd5});
        wait_neg(h + 4); chk("t5_set_y", 1, {cvalid[1], ctype[1], cdata[1]}, {1'b1, 3'b101, 16'd6});
        wait_neg(h + 5); chk("t5_done_no_on", 1, {done[1], cvalid[1]}, 2'b10);
        wait_neg(h + 7);

        // 6: reset mid-sequence, pointer returns to req0
        request(0, 0, 16'd40, 16'd20, 16'd60, h);
        wait_neg(h + 4);
        tick; srst[0] = 1'b1;
        tick; srst[0] = 1'b0;
        @(negedge clk);
        chk("t6_outputs_zero", 0, {cvalid[0], ctype[0], cdata[0], busy[0], done[0], abrt[0]}, 0);
        @(negedge clk);
        chk("t6_no_set_r", 0, cvalid[0], 1'b0);
        tick;
        v[0][0] = 1'b1; in_r[0][0] = 16'd1; in_y[0][0] = 16'd1; in_g[0][0] = 16'd1;
        v[0][1] = 1'b1;
        @(negedge clk);
        chk("t6_ptr_reset_req0", 0, {rdy[0][0], rdy[0][1]}, 2'b10);
        h = cyc;
        tick; v[0][0] = 1'b0; v[0][1] = 1'b0;
        wait_neg(h + 18);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
